vga_scanout: RTL and testbench

//  Read-side master of the SPRAM frame buffer: generates VGA 640x480@60 timing,

---
 rtl/vga_scanout.sv | 194 +++++++++++++++++++
 tb/tb_vga_scanout.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: VGA 640x480@60 scanout master reading the SPRAM frame buffer.
// Build option: define TEST_PATTERN_EN to add patSel and the built-in checker.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RD_LAT   = 1
) (
  input  logic        mainClk,
  input  logic        nRst,
  input  logic        pixEn,
  output logic [9:0]  xCoordVga,
  output logic [8:0]  yCoordVga,
  input  logic [1:0]  pixVal,
`ifdef TEST_PATTERN_EN
  input  logic        patSel,
`endif
  output logic        hSync,
  output logic        vSync,
  output logic        de,
  output logic [11:0] rgb,
  output logic        frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
`ifdef TEST_PATTERN_EN
    logic [1:0] pat;
`endif
  } tap_t;

  function automatic tap_t idle_tap();
    tap_t t;
    t    = '0;
    t.hs = 1'b1;
    t.vs = 1'b1;
    return t;
  endfunction

  logic [9:0]  hCnt_q, hCnt_d;
  logic [9:0]  vCnt_q, vCnt_d;
  logic        hWrap, vWrap;
  logic        fs_q, fs_d;

  tap_t        iss_q, iss_d;
  logic        act;
  logic [9:0]  xCoord_q, xCoord_d;
  logic [8:0]  yCoord_q, yCoord_d;

  tap_t        dly_q [RD_LAT];
  tap_t        tail;

  logic [1:0]  pixSel;
  logic [11:0] pal;
  logic [11:0] rgb_d;
  logic        ld_q;
  logic        hSync_q;
  logic        vSync_q;
  logic        de_q;
  logic [11:0] rgb_q;

  // Raster counters
  always_comb begin
    hWrap  = (hCnt_q == H_LAST);
    vWrap  = (vCnt_q == V_LAST);
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    fs_d   = 1'b0;
    if (pixEn) begin
      hCnt_d = hWrap ? '0 : hCnt_q + 10'd1;
      if (hWrap) begin
        vCnt_d = vWrap ? '0 : vCnt_q + 10'd1;
      end
      fs_d = hWrap && vWrap;
    end
  end

  always_ff @(posedge mainClk or negedge nRst) begin
    if (!nRst) begin
      hCnt_q <= '0;
      vCnt_q <= '0;
      fs_q   <= 1'b0;
    end else begin
      hCnt_q <= hCnt_d;
      vCnt_q <= vCnt_d;
      fs_q   <= fs_d;
    end
  end

  // Issue stage: blanking addresses are parked at 0
  always_comb begin
    act       = (hCnt_q < H_VIS) && (vCnt_q < V_VIS);
    iss_d     = idle_tap();
    iss_d.act = act;
    iss_d.hs  = !((hCnt_q >= HS_BEG) && (hCnt_q <= HS_END));
    iss_d.vs  = !((vCnt_q >= VS_BEG) && (vCnt_q <= VS_END));
`ifdef TEST_PATTERN_EN
    iss_d.pat = {hCnt_q[5] ^ vCnt_q[5], hCnt_q[4]};
`endif
    xCoord_d  = act ? hCnt_q : '0;
    yCoord_d  = act ? vCnt_q[8:0] : '0;
  end

  always_ff @(posedge mainClk or negedge nRst) begin
    if (!nRst) begin
      iss_q    <= idle_tap();
      xCoord_q <= '0;
      yCoord_q <= '0;
    end else if (pixEn) begin
      iss_q    <= iss_d;
      xCoord_q <= xCoord_d;
      yCoord_q <= yCoord_d;
    end
  end

  always_ff @(posedge mainClk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        dly_q[i] <= idle_tap();
      end
    end else if (pixEn) begin
      dly_q[0] <= iss_q;
      for (int i = 1; i < RD_LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign tail = dly_q[RD_LAT-1];

  always_comb begin
    pixSel = pixVal;
`ifdef TEST_PATTERN_EN
    if (patSel) begin
      pixSel = tail.pat;
    end
`endif
    pal = 12'h000;
    unique case (pixSel)
      2'b00: pal = 12'h000;
      2'b01: pal = 12'h555;
      2'b10: pal = 12'hAAA;
      2'b11: pal = 12'hFFF;
    endcase
    rgb_d = tail.act ? pal : 12'h000;
  end

  // Output register loads the mainClk after each strobe so it samples settled pixVal
  always_ff @(posedge mainClk or negedge nRst) begin
    if (!nRst) begin
      ld_q    <= 1'b0;
      hSync_q <= 1'b1;
      vSync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      ld_q <= pixEn;
      if (ld_q) begin
        hSync_q <= tail.hs;
        vSync_q <= tail.vs;
        de_q    <= tail.act;
        rgb_q   <= rgb_d;
      end
    end
  end

  assign xCoordVga  = xCoord_q;
  assign yCoordVga  = yCoord_q;
  assign hSync      = hSync_q;
  assign vSync      = vSync_q;
  assign de         = de_q;
  assign rgb        = rgb_q;
  assign frameStart = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: randomized bench for vga_scanout against a tick-indexed model.
// One full-size instance (lines) and one small-geometry instance (frames).
module tb_vga_scanout;

  localparam int LAT0 = 1;
  localparam int LAT1 = 2;
  localparam int S_HA = 64, S_HF = 8, S_HS = 12, S_HB = 6;
  localparam int S_VA = 40, S_VF = 3, S_VS = 2, S_VB = 4;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_FT = S_HT * S_VT;
  localparam int D_FT = 800 * 525;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic pixEn = 1'b0;
  logic [1:0] key = 2'd0;
`ifdef TEST_PATTERN_EN
  logic patSel = 1'b0;
`endif

  logic [9:0]  x0, x1;
  logic [8:0]  y0, y1;
  logic [1:0]  pv0, pv1;
  logic        hs0, vs0, de0, fs0;
  logic        hs1, vs1, de1, fs1;
  logic [11:0] rgb0, rgb1;

  always #5 clk = ~clk;

  vga_scanout #(.RD_LAT(LAT0)) u_full (
    .mainClk(clk), .nRst(nRst), .pixEn(pixEn),
    .xCoordVga(x0), .yCoordVga(y0), .pixVal(pv0),
`ifdef TEST_PATTERN_EN
    .patSel(patSel),
`endif
    .hSync(hs0), .vSync(vs0), .de(de0),
    .rgb(rgb0), .frameStart(fs0)
  );

  vga_scanout #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .RD_LAT(LAT1)
  ) u_small (
    .mainClk(clk), .nRst(nRst), .pixEn(pixEn),
    .xCoordVga(x1), .yCoordVga(y1), .pixVal(pv1),
`ifdef TEST_PATTERN_EN
    .patSel(patSel),
`endif
    .hSync(hs1), .vSync(vs1), .de(de1),
    .rgb(rgb1), .frameStart(fs1)
  );

  // Frame-buffer model: registered read, one stage per pixEn tick
  logic [1:0] rd0 [4] = '{default: 2'd0};
  logic [1:0] rd1 [4] = '{default: 2'd0};

  function automatic logic [1:0] mem(logic [9:0] x, logic [8:0] y,
                                     logic [1:0] k);
    return x[1:0] ^ y[1:0] ^ k;
  endfunction

  always @(posedge clk) begin
    if (pixEn) begin
      rd0[0] <= mem(x0, y0, key);
      rd1[0] <= mem(x1, y1, key);
      for (int i = 1; i < 4; i++) begin
        rd0[i] <= rd0[i-1];
        rd1[i] <= rd1[i-1];
      end
    end
  end

  assign pv0 = rd0[LAT0-1];
  assign pv1 = rd1[LAT1-1];

  // Reference: T = strobes since reset, ldT = strobe index shown at output
  int   T     = 0;
  int   ldT   = -1000;
  int   fsIdx = -1;
  logic peQ   = 1'b0;
  logic ldNow = 1'b0;

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      T     <= 0;
      ldT   <= -1000;
      fsIdx <= -1;
      peQ   <= 1'b0;
      ldNow <= 1'b0;
    end else begin
      ldNow <= peQ;
      if (peQ) ldT <= T - 1;
      peQ   <= pixEn;
      fsIdx <= pixEn ? T : -1;
      if (pixEn) T <= T + 1;
    end
  end

  function automatic logic pat_on();
`ifdef TEST_PATTERN_EN
    return patSel;
`else
    return 1'b0;
`endif
  endfunction

  // {hSync, vSync, de, rgb} for the pixel issued at strobe i
  function automatic logic [14:0] vid(int ha, int hf, int hsw, int hbp,
                                      int va, int vf, int vsw, int vbp,
                                      int i, logic [1:0] k, logic pat);
    int ht, vt, h, v;
    logic [9:0] hb, vb;
    logic [1:0] p;
    logic a, hs, vs;
    if (i < 0) return {1'b1, 1'b1, 1'b0, 12'h000};
    ht = ha + hf + hsw + hbp;
    vt = va + vf + vsw + vbp;
    h  = i % ht;
    v  = (i / ht) % vt;
    hb = 10'(h);
    vb = 10'(v);
    a  = (h < ha) && (v < va);
    p  = pat ? {hb[5] ^ vb[5], hb[4]} : (hb[1:0] ^ vb[1:0] ^ k);
    hs = !(h >= ha + hf && h < ha + hf + hsw);
    vs = !(v >= va + vf && v < va + vf + vsw);
    return {hs, vs, a, a ? 12'(12'h555 * p) : 12'h000};
  endfunction

  function automatic logic [18:0] crd(int ha, int ht, int va, int vt, int i);
    int h, v;
    if (i < 0) return '0;
    h = i % ht;
    v = (i / ht) % vt;
    if (h < ha && v < va) return {10'(h), 9'(v)};
    return '0;
  endfunction

  function automatic logic fs_exp(int ft);
    return fsIdx >= 0 && (fsIdx % ft) == ft - 1;
  endfunction

  int nChk = 0;
  int nPass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic chk_rst();
    chk("rst_full_out", 32'({hs0, vs0, de0, rgb0, fs0}), 32'(16'hC000));
    chk("rst_full_crd", 32'({x0, y0}), 32'd0);
    chk("rst_small_out", 32'({hs1, vs1, de1, rgb1, fs1}), 32'(16'hC000));
    chk("rst_small_crd", 32'({x1, y1}), 32'd0);
  endtask

  int   hsRun = 0, hsFall = -1, vsRun = 0;
  logic hsPrev = 1'b1, hsFirst = 1'b1;

  task automatic tick_check();
    logic [14:0] e0, e1;
    int i1, h1, v1;
    e0 = vid(640, 16, 96, 48, 480, 10, 2, 33, ldT - LAT0, key, pat_on());
    e1 = vid(S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB,
             ldT - LAT1, key, pat_on());
    chk("full_sync", 32'({hs0, vs0}), 32'(e0[14:13]));
    chk("full_de", 32'(de0), 32'(e0[12]));
    chk("full_rgb", 32'(rgb0), 32'(e0[11:0]));
    chk("full_coord", 32'({x0, y0}), 32'(crd(640, 800, 480, 525, T - 1)));
    chk("full_fs", 32'(fs0), 32'(fs_exp(D_FT)));
    chk("small_sync", 32'({hs1, vs1}), 32'(e1[14:13]));
    chk("small_de", 32'(de1), 32'(e1[12]));
    chk("small_rgb", 32'(rgb1), 32'(e1[11:0]));
    chk("small_coord", 32'({x1, y1}),
        32'(crd(S_HA, S_HT, S_VA, S_VT, T - 1)));
    chk("small_fs", 32'(fs1), 32'(fs_exp(S_FT)));
    if (!nRst) begin
      hsRun = 0; hsFall = -1; vsRun = 0;
      hsPrev = 1'b1; hsFirst = 1'b1;
    end else if (ldNow) begin
      if (!hs0 && hsPrev) begin
        if (hsFirst) chk("full_hs_first", 32'(ldT - LAT0), 32'd656);
        else chk("full_line_period", 32'(ldT - hsFall), 32'd800);
        hsFirst = 1'b0;
        hsFall  = ldT;
      end
      if (!hs0) hsRun++;
      else if (hsRun > 0) begin
        chk("full_hs_width", 32'(hsRun), 32'd96);
        hsRun = 0;
      end
      if (!vs1) vsRun++;
      else if (vsRun > 0) begin
        chk("small_vs_width", 32'(vsRun), 32'(S_VS * S_HT));
        vsRun = 0;
      end
      hsPrev = hs0;
      i1 = ldT - LAT1;
      if (i1 >= 0) begin
        h1 = i1 % S_HT;
        v1 = (i1 / S_HT) % S_VT;
        if (!pat_on() && key == 2'd0 && v1 == 0 && h1 == 2)
          chk("px_x2", 32'(rgb1), 32'h0AAA);
        if (!pat_on() && key == 2'd0 && v1 == 0 && h1 == 3)
          chk("px_x3", 32'(rgb1), 32'h0FFF);
`ifdef TEST_PATTERN_EN
        if (pat_on() && h1 == 32 && v1 == 0) chk("pat_32_0", 32'(rgb1), 32'h0AAA);
        if (pat_on() && h1 == 0 && v1 == 32) chk("pat_0_32", 32'(rgb1), 32'h0AAA);
        if (pat_on() && h1 == 32 && v1 == 32) chk("pat_32_32", 32'(rgb1), 32'h0000);
        if (pat_on() && h1 == 16 && v1 == 0) chk("pat_16_0", 32'(rgb1), 32'h0555);
`endif
      end
    end
  endtask

  int cyc = 0;

  // mode 0: random strobes, 1: every cycle, n: every n-th cycle
  task automatic step(input int mode);
    @(negedge clk);
    tick_check();
    cyc++;
    case (mode)
      0:       pixEn = ($urandom % 3) != 0;
      1:       pixEn = 1'b1;
      default: pixEn = (cyc % mode) == 0;
    endcase
  endtask

  task automatic do_reset(input logic [1:0] k);
    @(negedge clk);
    tick_check();
    nRst = 1'b0;
    #1;
    chk_rst();
    key = k;
    repeat (3) step(1);
    nRst = 1'b1;
  endtask

  int n;

  initial begin
    do_reset(2'd0);
    for (int c = 0; c < 3 * S_FT + 200; c++) step(1);
    for (int c = 0; c < 4 * S_FT + 100; c++) step(4);
    n = 0;
    while ((T % S_FT) != 20 * S_HT + 32 && n < 20000) begin
      step(4);
      n++;
    end
    if (n >= 20000) chk("mid_frame_wait", 32'd0, 32'd1);
`ifdef TEST_PATTERN_EN
    patSel = 1'b1;
`endif
    do_reset(2'($urandom));
    for (int c = 0; c < 2 * S_FT + 200; c++) step(0);
`ifdef TEST_PATTERN_EN
    patSel = 1'b0;
`endif
    do_reset(2'($urandom));
    for (int c = 0; c < 3000; c++) step(1);
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
